// File: rtl/pipe_add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding, flag bundle
// and the per-stage chunk width helper.
package pipe_add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;

  function automatic int chunk_w(input int width, input int stages);
    if (stages < 1) begin
      return 0;
    end else begin
      return width / stages;
    end
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit ripple adder with carry in/out; each bit is a full-add cell
// made of two half-add steps whose carries are OR-merged.
module add_chunk
  import pipe_add_sub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic carry_s;
  logic half_s;

  // ripple the carry from bit 0 upward
  always_comb begin
    sum     = {W{1'b0}};
    carry_s = cin;
    half_s  = 1'b0;
    for (int i = 0; i < W; i++) begin
      half_s  = a[i] ^ b[i];
      sum[i]  = half_s ^ carry_s;
      carry_s = (a[i] & b[i]) | (half_s & carry_s);
    end
    cout = carry_s;
  end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined two's-complement add/sub with valid/ready flow control; one CHUNK of the
// carry chain resolves per stage. Optional result saturation: PIPE_ADD_SUB_SAT_EN.
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
`ifdef PIPE_ADD_SUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if ((WIDTH < 2) || (STAGES < 1) || (CHUNK * STAGES != WIDTH)) begin : g_bad_param
    $fatal(1, "pipe_add_sub: illegal WIDTH/STAGES combination");
  end

  logic             v_r   [STAGES];
  logic             c_r   [STAGES];
  logic [WIDTH-1:0] res_r [STAGES];
  logic [WIDTH-1:0] a_r   [STAGES];
  logic [WIDTH-1:0] b_r   [STAGES];
  flags_t           flags_r;

  logic             src_v    [STAGES];
  logic             src_c    [STAGES];
  logic [WIDTH-1:0] src_a    [STAGES];
  logic [WIDTH-1:0] src_b    [STAGES];
  logic [WIDTH-1:0] src_res  [STAGES];
  logic [WIDTH-1:0] res_nx_s [STAGES];
  logic [CHUNK-1:0] sum_s    [STAGES];
  logic             cout_s   [STAGES];
  logic             adv_s    [STAGES];

`ifdef PIPE_ADD_SUB_SAT_EN
  logic sat_r   [STAGES];
  logic src_sat [STAGES];
`endif

  logic [WIDTH-1:0] fin_res_s;
  flags_t           fin_flags_s;
  logic             sign_a_s;
  logic             sign_b_s;
  logic             ovf_s;

  // Stage 0 takes the ports (B inverted, carry-in 1 for SUB); later stages take the prior registers.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_v[k]   = in_valid & in_ready;
      assign src_a[k]   = a;
      assign src_b[k]   = (op == OP_SUB) ? ~b : b;
      assign src_c[k]   = (op == OP_SUB) ? 1'b1 : 1'b0;
      assign src_res[k] = {WIDTH{1'b0}};
`ifdef PIPE_ADD_SUB_SAT_EN
      assign src_sat[k] = sat;
`endif
    end else begin : g_body
      assign src_v[k]   = v_r[k-1];
      assign src_a[k]   = a_r[k-1];
      assign src_b[k]   = b_r[k-1];
      assign src_c[k]   = c_r[k-1];
      assign src_res[k] = res_r[k-1];
`ifdef PIPE_ADD_SUB_SAT_EN
      assign src_sat[k] = sat_r[k-1];
`endif
    end

    add_chunk #(.W(CHUNK)) u_chunk (
      .a    (src_a[k][k*CHUNK +: CHUNK]),
      .b    (src_b[k][k*CHUNK +: CHUNK]),
      .cin  (src_c[k]),
      .sum  (sum_s[k]),
      .cout (cout_s[k])
    );

    // bits above the resolved chunks are still zero, so OR-ing merges the new chunk
    assign res_nx_s[k] = src_res[k] | (WIDTH'(sum_s[k]) << (k * CHUNK));
  end

  // a stage may load when it is empty or its successor is moving on
  always_comb begin
    adv_s[LAST] = ~v_r[LAST] | out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv_s[k] = ~v_r[k] | adv_s[k+1];
    end
  end

  assign in_ready = adv_s[0] & ~rst;

  // final stage: signed overflow, optional clamp and zero detect on the delivered value
  always_comb begin
    sign_a_s  = src_a[LAST][WIDTH-1];
    sign_b_s  = src_b[LAST][WIDTH-1];
    ovf_s     = (sign_a_s == sign_b_s) && (res_nx_s[LAST][WIDTH-1] != sign_a_s);
    fin_res_s = res_nx_s[LAST];
`ifdef PIPE_ADD_SUB_SAT_EN
    if (src_sat[LAST] && ovf_s) begin
      fin_res_s = sign_a_s ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      fin_res_s = res_nx_s[LAST];
    end
`endif
    fin_flags_s.carry    = cout_s[LAST];
    fin_flags_s.overflow = ovf_s;
    fin_flags_s.zero     = ~|fin_res_s;
  end

  // pipeline registers; the last stage doubles as the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]   <= 1'b0;
        c_r[k]   <= 1'b0;
        res_r[k] <= {WIDTH{1'b0}};
        a_r[k]   <= {WIDTH{1'b0}};
        b_r[k]   <= {WIDTH{1'b0}};
`ifdef PIPE_ADD_SUB_SAT_EN
        sat_r[k] <= 1'b0;
`endif
      end
      flags_r <= flags_t'(3'b000);
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv_s[k]) begin
          v_r[k] <= src_v[k];
          if (src_v[k]) begin
            c_r[k]   <= cout_s[k];
            a_r[k]   <= src_a[k];
            b_r[k]   <= src_b[k];
            res_r[k] <= (k == LAST) ? fin_res_s : res_nx_s[k];
`ifdef PIPE_ADD_SUB_SAT_EN
            sat_r[k] <= src_sat[k];
`endif
          end
        end
      end
      if (adv_s[LAST] && src_v[LAST]) begin
        flags_r <= fin_flags_s;
      end
    end
  end

  assign out_valid = v_r[LAST];
  assign result    = res_r[LAST];
  assign carry_out = flags_r.carry;
  assign overflow  = flags_r.overflow;
  assign zero      = flags_r.zero;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench: 32-bit/4-stage DUT against an arithmetic scoreboard model,
// plus an 8-bit/1-stage DUT for the single-register configuration.
module tb_pipe_add_sub;
  import pipe_add_sub_pkg::*;

  localparam int W  = 32;
  localparam int S  = 4;
  localparam int SW = 8;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic          clk, rst;
  logic          in_valid, in_ready, op, sat, sat_eff;
  logic          out_valid, out_ready, carry_out, overflow, zero;
  logic [W-1:0]  a, b, result;
  logic          s_in_valid, s_in_ready, s_op, s_out_valid, s_out_ready;
  logic          s_carry, s_ovf, s_zero;
  logic [SW-1:0] s_a, s_b, s_result;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pop   = 0;
  exp_t exp_q[$];

  pipe_add_sub #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
`ifdef PIPE_ADD_SUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  pipe_add_sub #(.WIDTH(SW), .STAGES(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .op(s_op),
`ifdef PIPE_ADD_SUB_SAT_EN
    .sat(1'b0),
`endif
    .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
    .carry_out(s_carry), .overflow(s_ovf), .zero(s_zero)
  );

`ifdef PIPE_ADD_SUB_SAT_EN
  assign sat_eff = sat;
`else
  assign sat_eff = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic modulo 2^w, signed range test for overflow.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic o, input logic s, input int w);
    longint unsigned mask, ux, uy, full;
    longint          sx, sy, sr, smax, smin;
    exp_t            e;
    mask = (64'd1 << w) - 64'd1;
    ux   = 64'(x) & mask;
    uy   = 64'(y) & mask;
    full = o ? ((ux - uy) & mask) : (ux + uy);
    e.c  = o ? (ux >= uy) : (((full >> w) & 64'd1) != 64'd0);
    e.res = 32'(full & mask);
    sx = longint'(ux);
    if (ux[w-1]) sx = sx - (longint'(1) << w);
    sy = longint'(uy);
    if (uy[w-1]) sy = sy - (longint'(1) << w);
    sr   = o ? (sx - sy) : (sx + sy);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    e.v  = (sr > smax) || (sr < smin);
    if (s && e.v) e.res = (sx < 0) ? 32'(smin & longint'(mask)) : 32'(smax);
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // scoreboard: compare on every output transfer, record every input transfer
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check_eq("q_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("sb_out", 64'({result, carry_out, overflow, zero}), 64'(e));
          n_pop++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, op, sat_eff, W));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic direct(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic o, input logic s, input logic [W-1:0] er, input logic [2:0] ef);
    int n;
    out_ready = 1'b1;
    in_valid = 1'b1; a = x; b = y; op = o; sat = s;
    #1 check_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; sat = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_eq({tag, "_lat"}, 64'(n), 64'(S));
    check_eq({tag, "_res"}, 64'(result), 64'(er));
    check_eq({tag, "_flags"}, 64'({carry_out, overflow, zero}), 64'(ef));
    @(posedge clk); #1;
  endtask

  task automatic s_direct(input string tag, input logic [SW-1:0] x, input logic [SW-1:0] y,
                          input logic o, input logic [SW+2:0] ev);
    s_out_ready = 1'b1;
    s_in_valid = 1'b1; s_a = x; s_b = y; s_op = o;
    #1 check_eq({tag, "_rdy"}, 64'(s_in_ready), 64'd1);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    check_eq({tag, "_vld"}, 64'(s_out_valid), 64'd1);
    check_eq({tag, "_out"}, 64'({s_result, s_carry, s_ovf, s_zero}), 64'(ev));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int cyc;
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while (exp_q.size() > 0 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int   n_acc, cyc, pop0;
    logic rdy;
    exp_t e;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = OP_ADD; sat = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_op = OP_ADD; s_out_ready = 1'b0;
    #2;
    check_eq("rst_out", 64'({out_valid, result, carry_out, overflow, zero}), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_s_out", 64'({s_out_valid, s_result, s_carry}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    direct("add5_3",   32'h0000_0005, 32'h0000_0003, OP_ADD, 1'b0, 32'h0000_0008, 3'b000);
    direct("sub3_5",   32'h0000_0003, 32'h0000_0005, OP_SUB, 1'b0, 32'hFFFF_FFFE, 3'b000);
    direct("sub7_7",   32'h0000_0007, 32'h0000_0007, OP_SUB, 1'b0, 32'h0000_0000, 3'b101);
    direct("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 32'h8000_0000, 3'b010);
    direct("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 32'h0000_0000, 3'b101);
    direct("sub_ovf",  32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0, 32'h7FFF_FFFF, 3'b110);
`ifdef PIPE_ADD_SUB_SAT_EN
    direct("sat_pos",  32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b1, 32'h7FFF_FFFF, 3'b010);
    direct("sat_neg",  32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b1, 32'h8000_0000, 3'b110);
`endif

    // backpressure: fill with out_ready low, then release and stream
    out_ready = 1'b0; n_acc = 0; cyc = 0;
    while (n_acc < 4 && cyc < 20) begin
      in_valid = 1'b1; a = rand_operand(); b = rand_operand(); op = 1'($urandom_range(0, 1));
      #1 rdy = in_ready;
      @(posedge clk); #1; cyc++;
      if (rdy) n_acc++;
    end
    check_eq("bp_fill", 64'(n_acc), 64'd4);
    check_eq("bp_fill_cyc", 64'(cyc), 64'd4);
    a = rand_operand(); b = rand_operand(); op = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check_eq("bp_hold", 64'({out_valid, result, carry_out, overflow, zero}), 64'({1'b1, exp_q[0]}));
    end
    out_ready = 1'b1; pop0 = n_pop;
    for (int i = 0; i < 10; i++) begin
      if (n_acc < 10) begin
        in_valid = 1'b1;
        if (i > 0) begin
          a = rand_operand(); b = rand_operand(); op = 1'($urandom_range(0, 1));
        end
      end else begin
        in_valid = 1'b0;
      end
      #1 rdy = in_ready;
      @(posedge clk); #1;
      if (in_valid && rdy) n_acc++;
    end
    in_valid = 1'b0;
    check_eq("bp_stream", 64'(n_pop - pop0), 64'd10);
    check_eq("bp_acc", 64'(n_acc), 64'd10);
    drain("bp_drain");

    // bubble collapse: a stalled head must not block an empty upstream stage
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h0000_1234; b = 32'h0000_0034; op = OP_SUB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);
    in_valid = 1'b1; a = 32'h0000_0100; b = 32'h0000_0200; op = OP_ADD;
    #1 check_eq("bubble_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(3);
    check_eq("bubble_head", 64'({out_valid, result}), 64'({1'b1, 32'h0000_1200}));
    check_eq("bubble_rdy2", 64'(in_ready), 64'd1);
    pop0 = n_pop; out_ready = 1'b1; cyc = 0;
    while (n_pop - pop0 < 2 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check_eq("bubble_pops", 64'(n_pop - pop0), 64'd2);

    // asynchronous reset with operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'h0000_0100 + 32'(i); b = 32'h0000_0011; op = OP_ADD;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    idle(1);
    check_eq("pre_rst_head", 64'({out_valid, result}), 64'({1'b1, 32'h0000_0111}));
    rst = 1'b1;
    #1;
    check_eq("arst_out", 64'({out_valid, result, carry_out, overflow, zero}), 64'd0);
    check_eq("arst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("post_rst_stale", 64'(out_valid), 64'd0);
    end
    direct("post_rst", 32'h0000_0040, 32'h0000_0002, OP_ADD, 1'b0, 32'h0000_0042, 3'b000);

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = rand_operand(); b = rand_operand(); op = 1'($urandom_range(0, 1));
`ifdef PIPE_ADD_SUB_SAT_EN
      sat = 1'($urandom_range(0, 1));
`endif
      @(posedge clk); #1;
    end
    sat = 1'b0;
    drain("rand_drain");

    // single-stage 8-bit instance: latency 1 and wrap-around
    s_direct("s_wrap", 8'hFF, 8'h01, OP_ADD, {8'h00, 3'b101});
    s_direct("s_ovf",  8'h7F, 8'h01, OP_ADD, {8'h80, 3'b010});
    s_direct("s_sub",  8'h03, 8'h05, OP_SUB, {8'hFE, 3'b000});
    for (int i = 0; i < 8; i++) begin
      logic [SW-1:0] x, y;
      logic          o;
      x = 8'($urandom); y = 8'($urandom); o = 1'($urandom_range(0, 1));
      e = model(32'(x), 32'(y), o, 1'b0, SW);
      s_direct("s_rand", x, y, o, {e.res[SW-1:0], e.c, e.v, e.z});
    end
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_a = 8'h10; s_b = 8'h20; s_op = OP_ADD;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    check_eq("s_stall_rdy", 64'(s_in_ready), 64'd0);
    @(posedge clk); #1;
    check_eq("s_stall_hold", 64'({s_out_valid, s_result}), 64'({1'b1, 8'h30}));
    s_out_ready = 1'b1;
    #1 check_eq("s_release_rdy", 64'(s_in_ready), 64'd1);
    @(posedge clk); #1;
    check_eq("s_release_vld", 64'(s_out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
